// File: rtl/control_pipe_pkg.sv
// control_pipe_pkg: opcodes, control encodings and per-stage control words for the pipelined control path
package control_pipe_pkg;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} resultsrc_t;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} aluop_t;
  typedef struct packed {
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
    logic       jump;
    logic       branch;
    logic [1:0] aluop;
    logic       alusrc;
    logic [4:0] rd;
  } ctrl_t;
  typedef struct packed {
    logic  valid;
    ctrl_t c;
  } e_t;
  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic       memwrite;
    logic [4:0] rd;
  } m_t;
  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [4:0] rd;
  } w_t;
  function automatic ctrl_t main_dec(input logic [6:0] op, input logic [4:0] rd);
    ctrl_t c;
    c = '0;
    c.rd = rd;
    c.regwrite = op == OP_R || op == OP_LW || op == OP_ADDI || op == OP_JAL;
    c.resultsrc = op == OP_LW ? RES_MEM : op == OP_JAL ? RES_PC4 : RES_ALU;
    c.memwrite = op == OP_SW;
    c.jump = op == OP_JAL;
    c.branch = op == OP_BEQ;
    c.aluop = op == OP_R || op == OP_ADDI ? ALU_FUNCT : op == OP_BEQ ? ALU_SUB : ALU_ADD;
    c.alusrc = op == OP_LW || op == OP_SW || op == OP_ADDI;
    return c;
  endfunction
endpackage

// File: rtl/control_pipe_if.sv
// control_pipe_if: decode-stage controls, hazard inputs and per-stage control outputs
interface control_pipe_if;
  logic       alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d;
  logic [1:0] resultsrc_d, aluop_d;
  logic [4:0] rd_d;
  logic       valid_d, stall_e, flush_e, zero_e;
  logic       alusrc_e, branch_e, jump_e;
  logic [1:0] aluop_e;
  logic       resultsrc_e0;
  logic [4:0] rd_e, rd_m, rd_w;
  logic       regwrite_e, regwrite_m, regwrite_w;
  logic       memwrite_m;
  logic [1:0] resultsrc_m, resultsrc_w;
  logic       pcsrc_e;
  modport master (
    output alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d, resultsrc_d, aluop_d, rd_d,
           valid_d, stall_e, flush_e, zero_e,
    input  alusrc_e, branch_e, jump_e, aluop_e, resultsrc_e0, rd_e, rd_m, rd_w,
           regwrite_e, regwrite_m, regwrite_w, memwrite_m, resultsrc_m, resultsrc_w, pcsrc_e
  );
  modport slave (
    input  alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d, resultsrc_d, aluop_d, rd_d,
           valid_d, stall_e, flush_e, zero_e,
    output alusrc_e, branch_e, jump_e, aluop_e, resultsrc_e0, rd_e, rd_m, rd_w,
           regwrite_e, regwrite_m, regwrite_w, memwrite_m, resultsrc_m, resultsrc_w, pcsrc_e
  );
endinterface

// File: rtl/control_pipe_stage_reg.sv
// pipe_stage_reg: width-parameterised pipeline register with sync reset, hold-enable and clear
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (reset || clr) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/control_pipe.sv
// control_pipe: E/M/W control registers with stall/flush handling and qualified write enables
module control_pipe
  import control_pipe_pkg::*;
(
  input logic           clk,
  input logic           reset,
  control_pipe_if.slave p
);
  ctrl_t ctrl_d;
  e_t d_s, e_s;
  m_t m_d, m_s;
  w_t w_d, w_s;
  assign ctrl_d = '{regwrite: p.regwrite_d, resultsrc: p.resultsrc_d, memwrite: p.memwrite_d,
                    jump: p.jump_d, branch: p.branch_d, aluop: p.aluop_d, alusrc: p.alusrc_d,
                    rd: p.rd_d};
  // invalid slots become all-zero bubbles so undefined controls never enter E
  assign d_s = p.valid_d === 1'b1 ? '{valid: 1'b1, c: ctrl_d} : '0;
  assign m_d = '{valid: e_s.valid, regwrite: e_s.c.regwrite, resultsrc: e_s.c.resultsrc,
                 memwrite: e_s.c.memwrite, rd: e_s.c.rd};
  assign w_d = '{valid: m_s.valid, regwrite: m_s.regwrite, resultsrc: m_s.resultsrc, rd: m_s.rd};
  pipe_stage_reg #(.W($bits(e_t))) u_e (
    .clk(clk), .reset(reset), .en(!p.stall_e), .clr(p.flush_e), .d(d_s), .q(e_s)
  );
  // a held E instruction is sent downstream only once, so M takes a bubble while stalled
  pipe_stage_reg #(.W($bits(m_t))) u_m (
    .clk(clk), .reset(reset), .en(1'b1), .clr(p.stall_e), .d(m_d), .q(m_s)
  );
  pipe_stage_reg #(.W($bits(w_t))) u_w (
    .clk(clk), .reset(reset), .en(1'b1), .clr(1'b0), .d(w_d), .q(w_s)
  );
  assign p.alusrc_e     = e_s.c.alusrc;
  assign p.branch_e     = e_s.c.branch;
  assign p.jump_e       = e_s.c.jump;
  assign p.aluop_e      = e_s.c.aluop;
  assign p.resultsrc_e0 = e_s.c.resultsrc[0];
  assign p.rd_e         = e_s.c.rd;
  assign p.rd_m         = m_s.rd;
  assign p.rd_w         = w_s.rd;
  assign p.regwrite_e   = e_s.valid & e_s.c.regwrite;
  assign p.regwrite_m   = m_s.valid & m_s.regwrite & |m_s.rd;
  assign p.regwrite_w   = w_s.valid & w_s.regwrite & |w_s.rd;
  assign p.memwrite_m   = m_s.valid & m_s.memwrite;
  assign p.resultsrc_m  = m_s.resultsrc;
  assign p.resultsrc_w  = w_s.resultsrc;
  assign p.pcsrc_e      = e_s.valid & ((e_s.c.branch & p.zero_e) | e_s.c.jump);
endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: ports named clk and reset.
REQ-002 Ports SHALL be, as name / direction / width / meaning:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d  in  1 each  decode-stage controls
- resultsrc_d, aluop_d  in  2 each  decode-stage controls
- rd_d  in  5  destination register
- valid_d  in  1  decode slot holds a real instruction
- stall_e  in  1  hold the E register
- flush_e  in  1  insert a bubble into E
- zero_e  in  1  ALU zero flag for the E-stage instruction
- alusrc_e, branch_e, jump_e  out  1 each  E-stage controls
- aluop_e  out  2  E-stage control
- resultsrc_e0  out  1  bit 0 of resultsrc_e, driven to the hazard unit for load-use detection
- rd_e, rd_m, rd_w  out  5 each  destination register per stage
- regwrite_e, regwrite_m, regwrite_w  out  1 each  qualified register write per stage
- memwrite_m  out  1  data-memory write enable
- resultsrc_m, resultsrc_w  out  2 each  result select per stage
- pcsrc_e  out  1  taken branch or jump

Function
REQ-003 The block SHALL hold three pipeline registers, E, M and W, each carrying a valid bit plus the control fields still needed at or after that stage.
REQ-004 On each clock edge, E SHALL load from the D inputs when stall_e=0 and flush_e=0.
REQ-005 On each clock edge, E SHALL load a bubble when flush_e=1: valid and all controls 0, rd 0.
REQ-006 On each clock edge, E SHALL hold its contents when stall_e=1 and flush_e=0.
REQ-007 flush_e SHALL take priority over stall_e when both are 1.
REQ-008 M SHALL load from E and W SHALL load from M on every clock edge; stalls never freeze M or W.
REQ-009 When stall_e=1, M SHALL receive a bubble, so the held E instruction is not duplicated downstream.
REQ-010 Every per-stage regwrite and memwrite output SHALL be ANDed with that stage's valid bit.
REQ-011 regwrite_m and regwrite_w SHALL additionally be forced to 0 when the corresponding rd is 5'd0.
REQ-012 pcsrc_e SHALL equal valid_e AND ((branch_e AND zero_e) OR jump_e), and SHALL be combinational with zero-cycle latency.
REQ-013 A D-stage instruction with valid_d=0 SHALL enter E as a bubble.
REQ-014 Latency from the D inputs to the M outputs SHALL be 2 cycles, and to the W outputs 3 cycles, absent stalls.
REQ-015 Any X on a D-stage control input whose E-stage valid bit ends up 0 SHALL NOT propagate: bubbles carry defined zeros.

Reset
REQ-016 While reset=1 at a clock edge, all three stage registers SHALL clear: valid 0, all controls 0, rd 0.
REQ-017 Immediately after reset, every output SHALL be 0, including pcsrc_e.
REQ-018 Reset SHALL override stall_e and flush_e.
REQ-019 Reset asserted mid-stream SHALL discard all in-flight instructions in the same edge.

Structure
REQ-020 A shared package SHALL define:
- the opcode constants (R, LW, SW, BEQ, ADDI, JAL);
- the resultsrc encodings (00 ALU, 01 memory, 10 PC+4);
- the aluop encodings;
- a packed control-word typedef used for the D, E, M and W fields.
REQ-021 One sub-module, pipe_stage_reg, SHALL implement a parameterised-width register with synchronous reset, hold-enable and clear; the block SHALL instantiate it once per stage.

Verification
REQ-022 Load word (resultsrc_d=01, regwrite_d=1, rd_d=5, valid_d=1), no stall -> after 1 cycle resultsrc_e0=1; after 2 cycles rd_m=5 and regwrite_m=1; after 3 cycles resultsrc_w=01 and regwrite_w=1.
REQ-023 beq (branch_d=1) in E with zero_e=1 -> pcsrc_e=1 in the same cycle; with zero_e=0 -> pcsrc_e=0; with jump_e=1 -> pcsrc_e=1 regardless of zero_e.
REQ-024 stall_e=1 for 2 cycles with an addi in E -> E holds the addi; M receives 2 bubbles (regwrite_m=0); the addi reaches M exactly once after the stall is released.
REQ-025 stall_e=1 and flush_e=1 on the same edge -> E becomes a bubble and pcsrc_e=0 next cycle.
REQ-026 R-type with rd_d=0 and regwrite_d=1 -> regwrite_m=0 and regwrite_w=0.
REQ-027 reset=1 asserted while sw, beq and lw occupy E, M and W -> after the edge all outputs are 0, and memwrite_m stays 0 on the following cycle.
